tlb_cmd_ctrl: RTL and testbench

// Initiator side of the TLB management interface: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB

---
 rtl/tlb_cmd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tlb_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_cmd_ctrl.sv
// ============================================================================
// Module   : tlb_cmd_ctrl
// Purpose  : Initiator side of the TLB management interface. Sequences
//            TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB and returns CSR write-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_cmd_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [31:0]   inv_vaddr,

  input  logic [31:0]   csr_tlbidx,
  input  logic [31:0]   csr_tlbehi,
  input  logic [31:0]   csr_tlbelo0,
  input  logic [31:0]   csr_tlbelo1,
  input  logic [9:0]    csr_asid,
  input  logic [5:0]    csr_ecode,

  output logic          tlb_we,
  output logic          tlb_fill_mode,
  output logic [IW-1:0] tlb_w_index,
  output logic [IW-1:0] tlb_f_index,
  output logic [IW-1:0] tlb_r_index,
  output logic [18:0]   tlb_w_vpn2,
  output logic [9:0]    tlb_w_asid,
  output logic [5:0]    tlb_w_ps,
  output logic          tlb_w_e,
  output logic          tlb_w_g,
  output logic [19:0]   tlb_w_pfn0,
  output logic [19:0]   tlb_w_pfn1,
  output logic [1:0]    tlb_w_mat0,
  output logic [1:0]    tlb_w_mat1,
  output logic [1:0]    tlb_w_plv0,
  output logic [1:0]    tlb_w_plv1,
  output logic          tlb_w_d0,
  output logic          tlb_w_d1,
  output logic          tlb_w_v0,
  output logic          tlb_w_v1,

  output logic          tlb_check_mode,
  output logic [18:0]   tlb_s_vpn2,

  input  logic [18:0]   tlb_r_vpn2,
  input  logic [9:0]    tlb_r_asid,
  input  logic [5:0]    tlb_r_ps,
  input  logic          tlb_r_g,
  input  logic [19:0]   tlb_r_pfn0,
  input  logic [19:0]   tlb_r_pfn1,
  input  logic [1:0]    tlb_r_mat0,
  input  logic [1:0]    tlb_r_mat1,
  input  logic [1:0]    tlb_r_plv0,
  input  logic [1:0]    tlb_r_plv1,
  input  logic          tlb_r_d0,
  input  logic          tlb_r_d1,
  input  logic          tlb_r_v0,
  input  logic          tlb_r_v1,
  input  logic          tlb_rs_e,
  input  logic [IW-1:0] tlb_s_index,

  output logic [2:0]    tlb_clear_mem,
  output logic [31:0]   tlb_clear_vaddr,
  output logic [9:0]    tlb_clear_asid,

  output logic          done,
  output logic          err,
  output logic          csr_wb_valid,
  output logic [31:0]   csr_wb_idx,
  output logic [31:0]   csr_wb_ehi,
  output logic [31:0]   csr_wb_elo0,
  output logic [31:0]   csr_wb_elo1,
  output logic [9:0]    csr_wb_asid
);

  localparam logic [2:0]    OP_SRCH      = 3'd0;
  localparam logic [2:0]    OP_RD        = 3'd1;
  localparam logic [2:0]    OP_WR        = 3'd2;
  localparam logic [2:0]    OP_FILL      = 3'd3;
  localparam logic [2:0]    OP_INV       = 3'd4;
  localparam logic [4:0]    INV_OP_MAX   = 5'd6;
  localparam logic [5:0]    ECODE_REFILL = 6'h3F;
  localparam logic [IW-1:0] FILL_LAST    = IW'(TLBNUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    cmd_op;
  logic          cmd_err;
  logic [31:0]   cmd_idx;
  logic [31:0]   cmd_ehi;
  logic [31:0]   cmd_elo0;
  logic [31:0]   cmd_elo1;
  logic [9:0]    cmd_asid;
  logic [IW-1:0] fill_cnt;

  logic          accept;
  logic          req_err;
  logic [31:0]   srch_idx;
  logic [31:0]   rd_idx;
  logic [31:0]   rd_ehi;
  logic [31:0]   rd_elo0;
  logic [31:0]   rd_elo1;
  logic [9:0]    rd_asid;

  assign accept      = req_valid & req_ready;
  assign req_err     = (req_op > OP_INV) || ((req_op == OP_INV) && (inv_op > INV_OP_MAX));
  assign tlb_f_index = fill_cnt;

  // Search/read write-back images; sampled only on the EXEC->RESP edge.
  always_comb begin
    srch_idx = cmd_idx;
    rd_idx   = cmd_idx;
    rd_ehi   = 32'd0;
    rd_elo0  = 32'd0;
    rd_elo1  = 32'd0;
    rd_asid  = 10'd0;
    if (tlb_rs_e) begin
      srch_idx[31]      = 1'b0;
      srch_idx[IW-1:0]  = tlb_s_index;
      rd_idx[31]        = 1'b0;
      rd_idx[29:24]     = tlb_r_ps;
      rd_ehi            = {tlb_r_vpn2, 13'd0};
      rd_elo0           = {4'd0, tlb_r_pfn0, 1'b0, tlb_r_g, tlb_r_mat0, tlb_r_plv0, tlb_r_d0, tlb_r_v0};
      rd_elo1           = {4'd0, tlb_r_pfn1, 1'b0, tlb_r_g, tlb_r_mat1, tlb_r_plv1, tlb_r_d1, tlb_r_v1};
      rd_asid           = tlb_r_asid;
    end else begin
      srch_idx[31]      = 1'b1;
      rd_idx[31]        = 1'b1;
      rd_idx[29:24]     = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      cmd_op          <= OP_SRCH;
      cmd_err         <= 1'b0;
      cmd_idx         <= 32'd0;
      cmd_ehi         <= 32'd0;
      cmd_elo0        <= 32'd0;
      cmd_elo1        <= 32'd0;
      cmd_asid        <= 10'd0;
      fill_cnt        <= '0;
      tlb_we          <= 1'b0;
      tlb_fill_mode   <= 1'b0;
      tlb_w_index     <= '0;
      tlb_r_index     <= '0;
      tlb_w_vpn2      <= 19'd0;
      tlb_w_asid      <= 10'd0;
      tlb_w_ps        <= 6'd0;
      tlb_w_e         <= 1'b0;
      tlb_w_g         <= 1'b0;
      tlb_w_pfn0      <= 20'd0;
      tlb_w_pfn1      <= 20'd0;
      tlb_w_mat0      <= 2'd0;
      tlb_w_mat1      <= 2'd0;
      tlb_w_plv0      <= 2'd0;
      tlb_w_plv1      <= 2'd0;
      tlb_w_d0        <= 1'b0;
      tlb_w_d1        <= 1'b0;
      tlb_w_v0        <= 1'b0;
      tlb_w_v1        <= 1'b0;
      tlb_check_mode  <= 1'b0;
      tlb_s_vpn2      <= 19'd0;
      tlb_clear_mem   <= 3'd0;
      tlb_clear_vaddr <= 32'd0;
      tlb_clear_asid  <= 10'd0;
      done            <= 1'b0;
      err             <= 1'b0;
      csr_wb_valid    <= 1'b0;
      csr_wb_idx      <= 32'd0;
      csr_wb_ehi      <= 32'd0;
      csr_wb_elo0     <= 32'd0;
      csr_wb_elo1     <= 32'd0;
      csr_wb_asid     <= 10'd0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      csr_wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state          <= S_EXEC;
            req_ready      <= 1'b0;
            cmd_op         <= req_op;
            cmd_err        <= req_err;
            cmd_idx        <= csr_tlbidx;
            cmd_ehi        <= csr_tlbehi;
            cmd_elo0       <= csr_tlbelo0;
            cmd_elo1       <= csr_tlbelo1;
            cmd_asid       <= csr_asid;
            // TLB-facing strobes are raised here so they are valid for exactly the EXEC cycle.
            tlb_we         <= !req_err && ((req_op == OP_WR) || (req_op == OP_FILL));
            tlb_fill_mode  <= !req_err && (req_op == OP_FILL);
            tlb_check_mode <= !req_err && (req_op == OP_SRCH);
            tlb_s_vpn2     <= csr_tlbehi[31:13];
            tlb_r_index    <= csr_tlbidx[IW-1:0];
            tlb_w_index    <= csr_tlbidx[IW-1:0];
            tlb_w_vpn2     <= csr_tlbehi[31:13];
            tlb_w_asid     <= csr_asid;
            tlb_w_ps       <= csr_tlbidx[29:24];
            tlb_w_e        <= (csr_ecode == ECODE_REFILL) ? 1'b1 : ~csr_tlbidx[31];
            tlb_w_g        <= csr_tlbelo0[6] & csr_tlbelo1[6];
            tlb_w_pfn0     <= csr_tlbelo0[27:8];
            tlb_w_pfn1     <= csr_tlbelo1[27:8];
            tlb_w_mat0     <= csr_tlbelo0[5:4];
            tlb_w_mat1     <= csr_tlbelo1[5:4];
            tlb_w_plv0     <= csr_tlbelo0[3:2];
            tlb_w_plv1     <= csr_tlbelo1[3:2];
            tlb_w_d0       <= csr_tlbelo0[1];
            tlb_w_d1       <= csr_tlbelo1[1];
            tlb_w_v0       <= csr_tlbelo0[0];
            tlb_w_v1       <= csr_tlbelo1[0];
            if (!req_err && (req_op == OP_INV)) begin
              tlb_clear_mem   <= inv_op[2:0];
              tlb_clear_vaddr <= inv_vaddr;
              tlb_clear_asid  <= inv_asid;
            end
          end
        end

        S_EXEC: begin
          state          <= S_RESP;
          tlb_we         <= 1'b0;
          tlb_fill_mode  <= 1'b0;
          tlb_check_mode <= 1'b0;
          tlb_clear_mem  <= 3'd0;
          done           <= 1'b1;
          err            <= cmd_err;
          if (!cmd_err) begin
            case (cmd_op)
              OP_FILL: fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + 1'b1;
              OP_SRCH: begin
                csr_wb_valid <= 1'b1;
                csr_wb_idx   <= srch_idx;
                csr_wb_ehi   <= cmd_ehi;
                csr_wb_elo0  <= cmd_elo0;
                csr_wb_elo1  <= cmd_elo1;
                csr_wb_asid  <= cmd_asid;
              end
              OP_RD: begin
                csr_wb_valid <= 1'b1;
                csr_wb_idx   <= rd_idx;
                csr_wb_ehi   <= rd_ehi;
                csr_wb_elo0  <= rd_elo0;
                csr_wb_elo1  <= rd_elo1;
                csr_wb_asid  <= rd_asid;
              end
              default: ;
            endcase
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlb_cmd_ctrl.sv
// ============================================================================
// Module   : tb_tlb_cmd_ctrl
// Purpose  : Directed self-checking bench for tlb_cmd_ctrl with a small TLB model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_cmd_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_vaddr;
  logic [31:0] csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1;
  logic [9:0]  csr_asid;
  logic [5:0]  csr_ecode;
  logic        tlb_we, tlb_fill_mode;
  logic [3:0]  tlb_w_index, tlb_f_index, tlb_r_index;
  logic [18:0] tlb_w_vpn2;
  logic [9:0]  tlb_w_asid;
  logic [5:0]  tlb_w_ps;
  logic        tlb_w_e, tlb_w_g;
  logic [19:0] tlb_w_pfn0, tlb_w_pfn1;
  logic [1:0]  tlb_w_mat0, tlb_w_mat1, tlb_w_plv0, tlb_w_plv1;
  logic        tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1;
  logic        tlb_check_mode;
  logic [18:0] tlb_s_vpn2;
  logic [18:0] tlb_r_vpn2;
  logic [9:0]  tlb_r_asid;
  logic [5:0]  tlb_r_ps;
  logic        tlb_r_g;
  logic [19:0] tlb_r_pfn0, tlb_r_pfn1;
  logic [1:0]  tlb_r_mat0, tlb_r_mat1, tlb_r_plv0, tlb_r_plv1;
  logic        tlb_r_d0, tlb_r_d1, tlb_r_v0, tlb_r_v1;
  logic        tlb_rs_e;
  logic [3:0]  tlb_s_index;
  logic [2:0]  tlb_clear_mem;
  logic [31:0] tlb_clear_vaddr;
  logic [9:0]  tlb_clear_asid;
  logic        done, err, csr_wb_valid;
  logic [31:0] csr_wb_idx, csr_wb_ehi, csr_wb_elo0, csr_wb_elo1;
  logic [9:0]  csr_wb_asid;

  int errors = 0;
  int checks = 0;

  tlb_cmd_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vaddr(inv_vaddr),
    .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi), .csr_tlbelo0(csr_tlbelo0),
    .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid), .csr_ecode(csr_ecode),
    .tlb_we(tlb_we), .tlb_fill_mode(tlb_fill_mode), .tlb_w_index(tlb_w_index),
    .tlb_f_index(tlb_f_index), .tlb_r_index(tlb_r_index),
    .tlb_w_vpn2(tlb_w_vpn2), .tlb_w_asid(tlb_w_asid), .tlb_w_ps(tlb_w_ps),
    .tlb_w_e(tlb_w_e), .tlb_w_g(tlb_w_g), .tlb_w_pfn0(tlb_w_pfn0), .tlb_w_pfn1(tlb_w_pfn1),
    .tlb_w_mat0(tlb_w_mat0), .tlb_w_mat1(tlb_w_mat1), .tlb_w_plv0(tlb_w_plv0),
    .tlb_w_plv1(tlb_w_plv1), .tlb_w_d0(tlb_w_d0), .tlb_w_d1(tlb_w_d1),
    .tlb_w_v0(tlb_w_v0), .tlb_w_v1(tlb_w_v1),
    .tlb_check_mode(tlb_check_mode), .tlb_s_vpn2(tlb_s_vpn2),
    .tlb_r_vpn2(tlb_r_vpn2), .tlb_r_asid(tlb_r_asid), .tlb_r_ps(tlb_r_ps), .tlb_r_g(tlb_r_g),
    .tlb_r_pfn0(tlb_r_pfn0), .tlb_r_pfn1(tlb_r_pfn1), .tlb_r_mat0(tlb_r_mat0),
    .tlb_r_mat1(tlb_r_mat1), .tlb_r_plv0(tlb_r_plv0), .tlb_r_plv1(tlb_r_plv1),
    .tlb_r_d0(tlb_r_d0), .tlb_r_d1(tlb_r_d1), .tlb_r_v0(tlb_r_v0), .tlb_r_v1(tlb_r_v1),
    .tlb_rs_e(tlb_rs_e), .tlb_s_index(tlb_s_index),
    .tlb_clear_mem(tlb_clear_mem), .tlb_clear_vaddr(tlb_clear_vaddr),
    .tlb_clear_asid(tlb_clear_asid),
    .done(done), .err(err), .csr_wb_valid(csr_wb_valid),
    .csr_wb_idx(csr_wb_idx), .csr_wb_ehi(csr_wb_ehi), .csr_wb_elo0(csr_wb_elo0),
    .csr_wb_elo1(csr_wb_elo1), .csr_wb_asid(csr_wb_asid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small TLB model: write port on the clock, combinational read and search.
  typedef struct packed {
    logic e; logic [18:0] vpn2; logic [9:0] asid; logic [5:0] ps; logic g;
    logic [19:0] pfn0, pfn1; logic [1:0] mat0, mat1, plv0, plv1;
    logic d0, d1, v0, v1;
  } ent_t;
  ent_t mem [16];
  ent_t rent;
  logic mdl_clr;
  logic s_hit;
  logic [3:0] s_idx;

  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (tlb_we) begin
      mem[tlb_fill_mode ? tlb_f_index : tlb_w_index] <= '{tlb_w_e, tlb_w_vpn2, tlb_w_asid,
        tlb_w_ps, tlb_w_g, tlb_w_pfn0, tlb_w_pfn1, tlb_w_mat0, tlb_w_mat1, tlb_w_plv0,
        tlb_w_plv1, tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1};
    end
  end

  always_comb begin
    s_hit = 1'b0;
    s_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!s_hit && mem[i].e && (mem[i].vpn2 == tlb_s_vpn2)) begin
        s_hit = 1'b1;
        s_idx = 4'(i);
      end
    end
    rent = mem[tlb_r_index];
  end

  assign tlb_rs_e    = tlb_check_mode ? s_hit : rent.e;
  assign tlb_s_index = s_idx;
  assign tlb_r_vpn2 = rent.vpn2; assign tlb_r_asid = rent.asid; assign tlb_r_ps = rent.ps;
  assign tlb_r_g = rent.g; assign tlb_r_pfn0 = rent.pfn0; assign tlb_r_pfn1 = rent.pfn1;
  assign tlb_r_mat0 = rent.mat0; assign tlb_r_mat1 = rent.mat1;
  assign tlb_r_plv0 = rent.plv0; assign tlb_r_plv1 = rent.plv1;
  assign tlb_r_d0 = rent.d0; assign tlb_r_d1 = rent.d1;
  assign tlb_r_v0 = rent.v0; assign tlb_r_v1 = rent.v1;

  // Observations of one command: before accept (pre), EXEC (ex), RESP (rs), back in IDLE (id).
  logic [2:0]  pre_clear, ex_clear, rs_clear;
  logic        ex_we, ex_fm, ex_w_e, ex_w_g, ex_check, ex_done, rs_we;
  logic [3:0]  ex_windex, ex_findex;
  logic [18:0] ex_w_vpn2;
  logic [19:0] ex_w_pfn0;
  logic [31:0] ex_cvaddr;
  logic [9:0]  ex_casid;
  logic        rs_done, rs_err, rs_wbv, id_ready, id_done;
  logic [31:0] rs_idx, rs_ehi, rs_elo0, rs_elo1;
  logic [9:0]  rs_asid;

  task automatic run_cmd(input logic [2:0] op);
    logic [31:0] s_idx_v, s_ehi, s_elo0, s_elo1;
    logic [9:0]  s_asid;
    logic [5:0]  s_ecode;
    logic [4:0]  s_invop;
    int n = 0;
    while (!req_ready && n < 8) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: req_ready=%0b required=1", req_ready);
    end
    pre_clear = tlb_clear_mem;
    req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    ex_we = tlb_we; ex_fm = tlb_fill_mode; ex_windex = tlb_w_index; ex_findex = tlb_f_index;
    ex_w_e = tlb_w_e; ex_w_g = tlb_w_g; ex_w_vpn2 = tlb_w_vpn2; ex_w_pfn0 = tlb_w_pfn0;
    ex_clear = tlb_clear_mem; ex_cvaddr = tlb_clear_vaddr; ex_casid = tlb_clear_asid;
    ex_check = tlb_check_mode; ex_done = done;
    // Scramble operands while busy; req_valid stays high through EXEC.
    s_idx_v = csr_tlbidx; s_ehi = csr_tlbehi; s_elo0 = csr_tlbelo0; s_elo1 = csr_tlbelo1;
    s_asid = csr_asid; s_ecode = csr_ecode; s_invop = inv_op;
    csr_tlbidx = ~s_idx_v; csr_tlbehi = ~s_ehi; csr_tlbelo0 = ~s_elo0; csr_tlbelo1 = ~s_elo1;
    csr_asid = ~s_asid; csr_ecode = ~s_ecode; inv_op = ~s_invop; req_op = ~op;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rs_done = done; rs_err = err; rs_wbv = csr_wb_valid; rs_idx = csr_wb_idx;
    rs_ehi = csr_wb_ehi; rs_elo0 = csr_wb_elo0; rs_elo1 = csr_wb_elo1; rs_asid = csr_wb_asid;
    rs_we = tlb_we; rs_clear = tlb_clear_mem;
    @(posedge clk); #1;
    id_ready = req_ready; id_done = done;
    csr_tlbidx = s_idx_v; csr_tlbehi = s_ehi; csr_tlbelo0 = s_elo0; csr_tlbelo1 = s_elo1;
    csr_asid = s_asid; csr_ecode = s_ecode; inv_op = s_invop; req_op = op;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b exp 1", req_ready); end
    checks++; if (tlb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", tlb_we); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %0b%0b exp 00", done, err); end
    checks++; if (csr_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wbv: got %0b exp 0", csr_wb_valid); end
    checks++; if (tlb_clear_mem !== 3'd0) begin errors++; $display("FAIL rst_clear: got %0d exp 0", tlb_clear_mem); end
    checks++; if (tlb_f_index !== 4'd0) begin errors++; $display("FAIL rst_findex: got %0d exp 0", tlb_f_index); end
    checks++; if (tlb_w_e !== 1'b0 || tlb_check_mode !== 1'b0) begin errors++; $display("FAIL rst_we_chk: got %0b%0b exp 00", tlb_w_e, tlb_check_mode); end
    checks++; if (csr_wb_idx !== 32'd0) begin errors++; $display("FAIL rst_wbidx: got %h exp 0", csr_wb_idx); end
  endtask

  task automatic test_write();
    csr_tlbidx = 32'h0C00_0005; csr_tlbehi = 32'h1234_6ABC; csr_tlbelo0 = 32'h0ABC_DE5F;
    csr_tlbelo1 = 32'h0123_4561; csr_asid = 10'h02A; csr_ecode = 6'h00;
    run_cmd(3'd2);
    checks++; if (ex_we !== 1'b1 || ex_fm !== 1'b0) begin errors++; $display("FAIL wr_we_fm: got %0b%0b exp 10", ex_we, ex_fm); end
    checks++; if (ex_windex !== 4'd5) begin errors++; $display("FAIL wr_index: got %0d exp 5", ex_windex); end
    checks++; if (ex_w_e !== 1'b1 || ex_w_g !== 1'b1) begin errors++; $display("FAIL wr_e_g: got %0b%0b exp 11", ex_w_e, ex_w_g); end
    checks++; if (ex_w_vpn2 !== 19'h091A3) begin errors++; $display("FAIL wr_vpn2: got %h exp 091a3", ex_w_vpn2); end
    checks++; if (ex_w_pfn0 !== 20'hABCDE) begin errors++; $display("FAIL wr_pfn0: got %h exp abcde", ex_w_pfn0); end
    checks++; if (ex_done !== 1'b0 || rs_done !== 1'b1 || id_done !== 1'b0) begin errors++; $display("FAIL wr_latency: done ex/rs/id got %0b%0b%0b exp 010", ex_done, rs_done, id_done); end
    checks++; if (rs_we !== 1'b0 || rs_wbv !== 1'b0 || rs_err !== 1'b0) begin errors++; $display("FAIL wr_resp: we/wbv/err got %0b%0b%0b exp 000", rs_we, rs_wbv, rs_err); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b exp 1", id_ready); end
    // Write with ne=1 outside refill produces an invalid entry.
    csr_tlbidx = 32'h8C00_0006;
    run_cmd(3'd2);
    checks++; if (ex_w_e !== 1'b0 || ex_windex !== 4'd6) begin errors++; $display("FAIL wr_ne: e/index got %0b/%0d exp 0/6", ex_w_e, ex_windex); end
  endtask

  task automatic test_read();
    csr_tlbidx = 32'h0000_0005; csr_tlbehi = 32'hFFFF_FFFF; csr_asid = 10'h3FF;
    csr_tlbelo0 = 32'h0; csr_tlbelo1 = 32'h0;
    run_cmd(3'd1);
    checks++; if (ex_check !== 1'b0) begin errors++; $display("FAIL rd_chk: got %0b exp 0", ex_check); end
    checks++; if (rs_wbv !== 1'b1 || rs_done !== 1'b1) begin errors++; $display("FAIL rd_wbv: got %0b%0b exp 11", rs_wbv, rs_done); end
    checks++; if (rs_idx !== 32'h0C00_0005) begin errors++; $display("FAIL rd_idx: got %h exp 0c000005", rs_idx); end
    checks++; if (rs_ehi !== 32'h1234_6000) begin errors++; $display("FAIL rd_ehi: got %h exp 12346000", rs_ehi); end
    checks++; if (rs_elo0 !== 32'h0ABC_DE5F || rs_elo1 !== 32'h0123_4561) begin errors++; $display("FAIL rd_elo: got %h %h exp 0abcde5f 01234561", rs_elo0, rs_elo1); end
    checks++; if (rs_asid !== 10'h02A) begin errors++; $display("FAIL rd_asid: got %h exp 02a", rs_asid); end
    // Entry 7 was never written.
    csr_tlbidx = 32'h0C00_0007; csr_tlbelo0 = 32'h1234_5678; csr_tlbelo1 = 32'h8765_4321;
    run_cmd(3'd1);
    checks++; if (rs_idx !== 32'h8000_0007) begin errors++; $display("FAIL rdinv_idx: got %h exp 80000007", rs_idx); end
    checks++; if (rs_ehi !== 32'd0 || rs_elo0 !== 32'd0 || rs_elo1 !== 32'd0 || rs_asid !== 10'd0) begin
      errors++; $display("FAIL rdinv_zero: got %h %h %h %h exp all 0", rs_ehi, rs_elo0, rs_elo1, rs_asid);
    end
  endtask

  task automatic test_fill();
    csr_tlbidx = 32'h8C00_0003; csr_ecode = 6'h3F; csr_asid = 10'h02A;
    for (int i = 0; i < 17; i++) begin
      csr_tlbehi  = {19'(32'h100 + i), 13'd0};
      csr_tlbelo0 = {4'd0, 20'(32'h500 + i), 8'h43};
      csr_tlbelo1 = {4'd0, 20'(32'h600 + i), 8'h41};
      run_cmd(3'd3);
      checks++; if (ex_findex !== 4'(i % 16)) begin errors++; $display("FAIL fill_index[%0d]: got %0d exp %0d", i, ex_findex, i % 16); end
      checks++; if (ex_we !== 1'b1 || ex_fm !== 1'b1) begin errors++; $display("FAIL fill_we_fm[%0d]: got %0b%0b exp 11", i, ex_we, ex_fm); end
      checks++; if (ex_w_e !== 1'b1) begin errors++; $display("FAIL fill_e[%0d]: got %0b exp 1", i, ex_w_e); end
    end
    csr_tlbidx = 32'h0000_000F; csr_ecode = 6'h00; csr_tlbehi = 32'h0;
    run_cmd(3'd1);
    checks++; if (rs_idx !== 32'h0C00_000F) begin errors++; $display("FAIL fill_rd_idx: got %h exp 0c00000f", rs_idx); end
    checks++; if (rs_ehi !== 32'h0021_E000) begin errors++; $display("FAIL fill_rd_ehi: got %h exp 0021e000", rs_ehi); end
    checks++; if (rs_elo0 !== 32'h0005_0F43 || rs_elo1 !== 32'h0006_0F41) begin errors++; $display("FAIL fill_rd_elo: got %h %h exp 00050f43 00060f41", rs_elo0, rs_elo1); end
  endtask

  task automatic test_search();
    csr_tlbidx = 32'h8C00_0003; csr_tlbehi = 32'h0021_205A; csr_asid = 10'h155;
    csr_tlbelo0 = 32'h1111_1111; csr_tlbelo1 = 32'h2222_2222;
    run_cmd(3'd0);
    checks++; if (ex_check !== 1'b1) begin errors++; $display("FAIL srch_chk: got %0b exp 1", ex_check); end
    checks++; if (rs_idx !== 32'h0C00_0009 || rs_wbv !== 1'b1) begin errors++; $display("FAIL srch_hit: idx/wbv got %h/%0b exp 0c000009/1", rs_idx, rs_wbv); end
    checks++; if (rs_ehi !== 32'h0021_205A || rs_asid !== 10'h155) begin errors++; $display("FAIL srch_pass: got %h %h exp 0021205a 155", rs_ehi, rs_asid); end
    csr_tlbidx = 32'h0C00_0003; csr_tlbehi = 32'h7FFF_E000;
    run_cmd(3'd0);
    checks++; if (rs_idx !== 32'h8C00_0003) begin errors++; $display("FAIL srch_miss: got %h exp 8c000003", rs_idx); end
    checks++; if (rs_elo0 !== 32'h1111_1111 || rs_elo1 !== 32'h2222_2222) begin errors++; $display("FAIL srch_elo: got %h %h exp 11111111 22222222", rs_elo0, rs_elo1); end
  endtask

  task automatic test_invtlb();
    inv_op = 5'd5; inv_asid = 10'h012; inv_vaddr = 32'h8000_2000;
    run_cmd(3'd4);
    checks++; if (pre_clear !== 3'd0 || ex_clear !== 3'd5 || rs_clear !== 3'd0) begin errors++; $display("FAIL inv_clear: pre/ex/rs got %0d/%0d/%0d exp 0/5/0", pre_clear, ex_clear, rs_clear); end
    checks++; if (ex_cvaddr !== 32'h8000_2000 || ex_casid !== 10'h012) begin errors++; $display("FAIL inv_opnd: got %h %h exp 80002000 012", ex_cvaddr, ex_casid); end
    checks++; if (ex_we !== 1'b0 || rs_done !== 1'b1 || rs_err !== 1'b0 || rs_wbv !== 1'b0) begin errors++; $display("FAIL inv_resp: we/done/err/wbv got %0b%0b%0b%0b exp 0100", ex_we, rs_done, rs_err, rs_wbv); end
    checks++; if (ex_findex !== 4'd1) begin errors++; $display("FAIL inv_fillcnt: got %0d exp 1", ex_findex); end
    inv_op = 5'd7;
    run_cmd(3'd4);
    checks++; if (ex_clear !== 3'd0 || rs_done !== 1'b1 || rs_err !== 1'b1) begin errors++; $display("FAIL inv_bad: clear/done/err got %0d/%0b/%0b exp 0/1/1", ex_clear, rs_done, rs_err); end
    inv_op = 5'd0; csr_tlbidx = 32'h0000_0002;
    run_cmd(3'd6);
    checks++; if (ex_we !== 1'b0 || ex_check !== 1'b0 || rs_err !== 1'b1 || rs_wbv !== 1'b0) begin errors++; $display("FAIL op_illegal: we/chk/err/wbv got %0b%0b%0b%0b exp 0010", ex_we, ex_check, rs_err, rs_wbv); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] done_pat, ready_pat;
    done_pat = '0; ready_pat = '0;
    csr_tlbidx = 32'h0000_0005; req_op = 3'd1; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      done_pat[i] = done; ready_pat[i] = req_ready;
    end
    req_valid = 1'b0;
    checks++; if (done_pat !== 6'b010010) begin errors++; $display("FAIL b2b_done: got %b exp 010010", done_pat); end
    checks++; if (ready_pat !== 6'b100100) begin errors++; $display("FAIL b2b_ready: got %b exp 100100", ready_pat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    csr_tlbidx = 32'h0C00_0005; csr_ecode = 6'h00; req_op = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (tlb_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we: got %0b exp 1", tlb_we); end
    rst = 1'b1; #1;
    checks++; if (tlb_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst: we/ready got %0b%0b exp 01", tlb_we, req_ready); end
    checks++; if (tlb_f_index !== 4'd0) begin errors++; $display("FAIL mid_fillcnt: got %0d exp 0", tlb_f_index); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || tlb_we || err) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_after: done/we cycles got %0d exp 0", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mdl_clr = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    inv_op = 5'd0; inv_asid = 10'd0; inv_vaddr = 32'd0;
    csr_tlbidx = 32'd0; csr_tlbehi = 32'd0; csr_tlbelo0 = 32'd0; csr_tlbelo1 = 32'd0;
    csr_asid = 10'd0; csr_ecode = 6'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mdl_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_fill();
    test_search();
    test_invtlb();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
